// File: rtl/rng_uniform_to_float_multiword_pkg.sv
// Shared constants and types for the uniform-to-float converter.
// Word widths, bias and the multi-word exponent extension limit.
package rng_uniform_to_float_multiword_pkg;

    localparam int RNG_BY        = 32;
    localparam int RNG_MANT_BW   = 23;
    localparam int RNG_EXP_PART  = 9;
    localparam int RNG_EXP_BW    = 8;
    localparam int RNG_BIAS      = 127;
    localparam int RNG_MAX_WORDS = 4;

    localparam int RNG_WORDS_W = $clog2(RNG_MAX_WORDS) + 1;
    localparam int RNG_LZ_W    = $clog2(RNG_MAX_WORDS * RNG_EXP_PART + 1);

    typedef enum logic {
        IDLE,
        ACCUM
    } conv_state_t;

endpackage

// File: rtl/rng_uniform_to_float_multiword_if.sv
// Valid/ready bundle between the URNG word source, the converter
// and the float consumer.
interface rng_uniform_to_float_multiword_if
    import rng_uniform_to_float_multiword_pkg::*;
#(
    parameter int BY      = RNG_BY,
    parameter int FLT_W   = RNG_EXP_BW + RNG_MANT_BW,
    parameter int WORDS_W = RNG_WORDS_W
);
    logic               in_valid;
    logic               in_ready;
    logic [BY-1:0]      uniform;
    logic               out_valid;
    logic               out_ready;
    logic [FLT_W-1:0]   floating;
    logic               out_underflow;
    logic [WORDS_W-1:0] out_words;

    modport master (
        output in_valid, uniform, out_ready,
        input  in_ready, out_valid, floating, out_underflow, out_words
    );

    modport slave (
        input  in_valid, uniform, out_ready,
        output in_ready, out_valid, floating, out_underflow, out_words
    );

endinterface

// File: rtl/rng_uniform_to_float_multiword_clz.sv
// Count of leading zeros of a W-bit value; all-zero input yields W.
module rng_uniform_to_float_multiword_clz #(
    parameter int W  = 9,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  value,
    output logic [CW-1:0] count
);

    // Ascending scan: the highest set bit is the last one to win.
    always_comb begin
        count = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (value[i]) count = CW'(W - 1 - i);
        end
    end

endmodule

// File: rtl/rng_uniform_to_float_multiword.sv
// Uniform words to normalised floats, extending the exponent range
// by chaining extra words while the exponent field is all zero.
module rng_uniform_to_float_multiword
    import rng_uniform_to_float_multiword_pkg::*;
#(
    parameter int BY        = RNG_BY,
    parameter int MANT_BW   = RNG_MANT_BW,
    parameter int EXP_PART  = RNG_EXP_PART,
    parameter int EXP_BW    = RNG_EXP_BW,
    parameter int BIAS      = RNG_BIAS,
    parameter int MAX_WORDS = RNG_MAX_WORDS
) (
    input logic clock,
    input logic reset,
    rng_uniform_to_float_multiword_if.slave bus
);

    localparam int WORDS_W = $clog2(MAX_WORDS) + 1;
    localparam int LZ_W    = $clog2(MAX_WORDS * EXP_PART + 1);
    localparam int CLZ_W   = $clog2(EXP_PART + 1);

    conv_state_t        state;
    logic [LZ_W-1:0]    lz_acc;
    logic [WORDS_W-1:0] word_cnt;

    logic [EXP_PART-1:0] e;
    logic [MANT_BW-1:0]  m;
    logic [CLZ_W-1:0]    e_lz;
    logic [LZ_W-1:0]     lz_base;
    logic [LZ_W-1:0]     lz_total;
    logic [EXP_BW-1:0]   exp_val;
    logic                accept;

    assign e = bus.uniform[BY-1 -: EXP_PART];
    assign m = bus.uniform[MANT_BW-1:0];

    assign bus.in_ready = !bus.out_valid || bus.out_ready;
    assign accept = bus.in_valid && bus.in_ready;

    rng_uniform_to_float_multiword_clz #(
        .W (EXP_PART)
    ) u_clz (
        .value (e),
        .count (e_lz)
    );

    assign lz_base  = (state == ACCUM) ? lz_acc : '0;
    assign lz_total = lz_base + LZ_W'(e_lz);
    assign exp_val  = EXP_BW'(BIAS - 1) - EXP_BW'(lz_total);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            lz_acc            <= '0;
            word_cnt          <= '0;
            bus.out_valid     <= 1'b0;
            bus.floating      <= '0;
            bus.out_underflow <= 1'b0;
            bus.out_words     <= '0;
        end else begin
            if (bus.out_valid && bus.out_ready) bus.out_valid <= 1'b0;
            if (accept) begin
                if (e != '0) begin
                    bus.out_valid     <= 1'b1;
                    bus.floating      <= {exp_val, m};
                    bus.out_underflow <= 1'b0;
                    bus.out_words     <= word_cnt + 1'b1;
                    lz_acc            <= '0;
                    word_cnt          <= '0;
                    state             <= IDLE;
                end else if (word_cnt == WORDS_W'(MAX_WORDS - 1)) begin
                    bus.out_valid     <= 1'b1;
                    bus.floating      <= '0;
                    bus.out_underflow <= 1'b1;
                    bus.out_words     <= WORDS_W'(MAX_WORDS);
                    lz_acc            <= '0;
                    word_cnt          <= '0;
                    state             <= IDLE;
                end else begin
                    lz_acc   <= lz_base + LZ_W'(EXP_PART);
                    word_cnt <= word_cnt + 1'b1;
                    state    <= ACCUM;
                end
            end
        end
    end

endmodule

// File: tb/tb_rng_uniform_to_float_multiword.sv
// Directed-vector bench for the multi-word uniform-to-float converter.
module tb_rng_uniform_to_float_multiword;

    logic clock;
    logic reset;
    int   vectors;
    int   miscompares;

    rng_uniform_to_float_multiword_if bus ();

    rng_uniform_to_float_multiword dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Present one word for one cycle; returns at the following negedge.
    task automatic send(input logic [31:0] w);
        @(negedge clock);
        bus.in_valid = 1'b1;
        bus.uniform  = w;
        @(negedge clock);
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.in_valid  = 1'b0;
        bus.uniform   = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clock);
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.floating !== 32'h0 ||
            bus.out_underflow !== 1'b0 || bus.out_words !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got v=%b f=%h u=%b w=%0d want 0 0 0 0",
                     bus.out_valid, bus.floating, bus.out_underflow, bus.out_words);
        end
        reset = 1'b0;
        @(negedge clock);
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
        end
    endtask

    task automatic test_single(input logic [31:0] w, input logic [31:0] exp_f);
        send(w);
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.floating !== exp_f ||
            bus.out_underflow !== 1'b0 || bus.out_words !== 3'd1) begin
            miscompares++;
            $display("FAIL single_%h: got v=%b f=%h u=%b w=%0d want 1 %h 0 1",
                     w, bus.out_valid, bus.floating, bus.out_underflow,
                     bus.out_words, exp_f);
        end
        @(negedge clock);
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_drop_%h: out_valid got %b want 0", w, bus.out_valid);
        end
    endtask

    task automatic test_two_words();
        send(32'h007F_FFFF);
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL two_words_early: out_valid got %b want 0", bus.out_valid);
        end
        send(32'h8000_0000);
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.floating !== 32'h3A80_0000 ||
            bus.out_underflow !== 1'b0 || bus.out_words !== 3'd2) begin
            miscompares++;
            $display("FAIL two_words: got v=%b f=%h u=%b w=%0d want 1 3a800000 0 2",
                     bus.out_valid, bus.floating, bus.out_underflow, bus.out_words);
        end
        @(negedge clock);
    endtask

    task automatic test_underflow();
        logic [31:0] words [4];
        words[0] = 32'h0000_0000;
        words[1] = 32'h0012_3456;
        words[2] = 32'h0000_0001;
        words[3] = 32'h007F_FFFF;
        for (int i = 0; i < 3; i++) begin
            send(words[i]);
            vectors++;
            if (bus.out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL underflow_early_%0d: out_valid got %b want 0",
                         i, bus.out_valid);
            end
        end
        send(words[3]);
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.floating !== 32'h0 ||
            bus.out_underflow !== 1'b1 || bus.out_words !== 3'd4) begin
            miscompares++;
            $display("FAIL underflow: got v=%b f=%h u=%b w=%0d want 1 0 1 4",
                     bus.out_valid, bus.floating, bus.out_underflow, bus.out_words);
        end
        @(negedge clock);
    endtask

    task automatic test_hold_idle();
        send(32'h0000_0000);
        repeat (3) @(negedge clock);
        send(32'h8000_0000);
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.floating !== 32'h3A80_0000 ||
            bus.out_words !== 3'd2) begin
            miscompares++;
            $display("FAIL hold_idle: got v=%b f=%h w=%0d want 1 3a800000 2",
                     bus.out_valid, bus.floating, bus.out_words);
        end
        @(negedge clock);
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b0;
        send(32'hFFFF_FFFF);
        bus.in_valid = 1'b1;
        bus.uniform  = 32'h4000_0000;
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 ||
                bus.floating !== 32'h3F7F_FFFF) begin
                miscompares++;
                $display("FAIL backpressure_%0d: got r=%b v=%b f=%h want 0 1 3f7fffff",
                         i, bus.in_ready, bus.out_valid, bus.floating);
            end
            @(negedge clock);
        end
        bus.out_ready = 1'b1;
        #1;
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL release_in_ready: got %b want 1", bus.in_ready);
        end
        @(negedge clock);
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.floating !== 32'h3E80_0000) begin
            miscompares++;
            $display("FAIL drain_load: got v=%b f=%h want 1 3e800000",
                     bus.out_valid, bus.floating);
        end
        bus.uniform = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            vectors++;
            if (bus.out_valid !== 1'b1 || bus.floating !== 32'h3F7F_FFFF ||
                bus.out_words !== 3'd1) begin
                miscompares++;
                $display("FAIL stream_%0d: got v=%b f=%h w=%0d want 1 3f7fffff 1",
                         i, bus.out_valid, bus.floating, bus.out_words);
            end
        end
        bus.in_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL stream_drop: out_valid got %b want 0", bus.out_valid);
        end
    endtask

    task automatic test_reset_mid();
        send(32'h0000_0000);
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.out_words !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_mid_async: got v=%b w=%0d want 0 0",
                     bus.out_valid, bus.out_words);
        end
        @(negedge clock);
        reset = 1'b0;
        send(32'h4000_0000);
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.floating !== 32'h3E80_0000 ||
            bus.out_words !== 3'd1) begin
            miscompares++;
            $display("FAIL reset_mid_discard: got v=%b f=%h w=%0d want 1 3e800000 1",
                     bus.out_valid, bus.floating, bus.out_words);
        end
        @(negedge clock);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_single(32'h4000_0000, 32'h3E80_0000);
        test_single(32'hFFFF_FFFF, 32'h3F7F_FFFF);
        test_two_words();
        test_underflow();
        test_hold_idle();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
